// File: rtl/square_analyzer.sv
// Square-wave analyzer: measures half-period, wave length and amplitude of a sample stream, locks onto a stable wave.
// Define SQUARE_ANALYZER_RESYNC_EN to drive the set/set_sample/set_counter generator resync strobe.
module square_analyzer #(
    parameter int          LOCK_COUNT = 3,
    parameter int          TOLERANCE  = 1,
    parameter logic [15:0] MAX_HALF   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [31:0] sample,
    output logic        locked,
    output logic [15:0] wave_length,
    output logic [31:0] amplitude,
    output logic [15:0] phase,
    output logic        polarity,
    output logic        set,
    output logic [31:0] set_sample,
    output logic [15:0] set_counter
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE_FIRST, ACQUIRE, LOCKED} state_t;

    localparam logic [4:0]  LOCK_TGT = 5'(LOCK_COUNT);
    localparam logic [15:0] TOL      = 16'(TOLERANCE);

    state_t      state_q, state_d;
    logic [15:0] half_count;
    logic [15:0] ref_half;
    logic [3:0]  match_cnt;
    logic [31:0] peak;

    logic        pol_in;
    logic        edge_det;
    logic        timeout;
    logic        is_match;
    logic        lock_hit;
    logic [31:0] abs_s;
    logic [31:0] peak_max;
    logic [15:0] diff;
    logic [4:0]  match_next;
    logic [16:0] twice;
    logic [15:0] wl_sat;

    // The most negative sample has no positive twin, so its magnitude saturates.
    always_comb begin
        pol_in     = ~sample[31];
        edge_det   = sample_valid && (pol_in != polarity);
        timeout    = sample_valid && !edge_det && (half_count == MAX_HALF);
        if (sample == 32'h8000_0000)
            abs_s = 32'h7FFF_FFFF;
        else if (sample[31])
            abs_s = -sample;
        else
            abs_s = sample;
        peak_max   = (abs_s > peak) ? abs_s : peak;
        diff       = (half_count >= ref_half) ? (half_count - ref_half) : (ref_half - half_count);
        is_match   = (diff <= TOL);
        match_next = {1'b0, match_cnt} + 5'd1;
        lock_hit   = is_match && (match_next >= LOCK_TGT);
        twice      = {ref_half, 1'b0};
        wl_sat     = twice[16] ? 16'hFFFF : twice[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= SEARCH;
        else
            state_q <= state_d;
    end

    // An edge always wins over a timeout on the same sample.
    always_comb begin
        state_d = state_q;
        if (edge_det) begin
            case (state_q)
                SEARCH:        state_d = ACQUIRE_FIRST;
                ACQUIRE_FIRST: state_d = ACQUIRE;
                ACQUIRE:       state_d = lock_hit ? LOCKED : ACQUIRE;
                LOCKED:        state_d = is_match ? LOCKED : ACQUIRE;
                default:       state_d = SEARCH;
            endcase
        end else if (timeout) begin
            state_d = SEARCH;
        end
    end

    always_comb begin
        locked = (state_q == LOCKED);
        phase  = half_count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            polarity    <= 1'b1;
            half_count  <= '0;
            ref_half    <= '0;
            match_cnt   <= '0;
            peak        <= '0;
            amplitude   <= '0;
            wave_length <= '0;
        end else if (sample_valid) begin
            if (edge_det) begin
                polarity   <= pol_in;
                half_count <= 16'd1;
                peak       <= abs_s;
                if (state_q != SEARCH)
                    amplitude <= peak;
                case (state_q)
                    ACQUIRE_FIRST: begin
                        ref_half  <= half_count;
                        match_cnt <= '0;
                    end
                    ACQUIRE: begin
                        if (is_match) begin
                            match_cnt <= match_next[3:0];
                            if (lock_hit)
                                wave_length <= wl_sat;
                        end else begin
                            ref_half  <= half_count;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_match) begin
                            ref_half  <= half_count;
                            match_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end else begin
                peak <= peak_max;
                if (timeout)
                    match_cnt <= '0;
                else
                    half_count <= half_count + 16'd1;
            end
        end
    end

`ifdef SQUARE_ANALYZER_RESYNC_EN
    logic set_hit;

    // The load counter is 2: the edge sample was count 1, plus one cycle of strobe latency.
    always_comb begin
        set_hit = edge_det && (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set         <= 1'b0;
            set_sample  <= '0;
            set_counter <= '0;
        end else begin
            set         <= set_hit;
            set_sample  <= set_hit ? (pol_in ? peak : -peak) : 32'd0;
            set_counter <= set_hit ? 16'd2 : 16'd0;
        end
    end
`else
    assign set         = 1'b0;
    assign set_sample  = '0;
    assign set_counter = '0;
`endif

endmodule

// File: tb/tb_square_analyzer.sv
// Randomized bench for square_analyzer against a half-period history model.
// Honours SQUARE_ANALYZER_RESYNC_EN for the expected resync strobe.
module tb_square_analyzer;

    localparam int LOCK = 3;
    localparam int TOL  = 1;
    localparam int MAXH = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [31:0] sample;
    logic        locked;
    logic [15:0] wave_length;
    logic [31:0] amplitude;
    logic [15:0] phase;
    logic        polarity;
    logic        set;
    logic [31:0] set_sample;
    logic [15:0] set_counter;

    always #5 clk = ~clk;

    square_analyzer #(
        .LOCK_COUNT(LOCK),
        .TOLERANCE (TOL),
        .MAX_HALF  (16'(MAXH))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample      (sample),
        .locked      (locked),
        .wave_length (wave_length),
        .amplitude   (amplitude),
        .phase       (phase),
        .polarity    (polarity),
        .set         (set),
        .set_sample  (set_sample),
        .set_counter (set_counter)
    );

    int total = 0;
    int bad   = 0;

    bit          m_pol;
    int          m_run;
    logic [31:0] m_peak;
    bit          m_seen;
    int          hist[$];
    bit          m_locked;
    int          m_wl;
    logic [31:0] m_amp;
    bit          e_set;
    logic [31:0] e_ss;
    int          e_sc;

    bit gap_en;
    bit next_pos;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        m_pol = 1'b1; m_run = 0; m_peak = '0; m_seen = 1'b0;
        hist.delete();
        m_locked = 1'b0; m_wl = 0; m_amp = '0;
        e_set = 1'b0; e_ss = '0; e_sc = 0;
    endfunction

    // Replay every complete half since the last restart to decide lock and the wave length at lock time.
    function automatic void walkHistory();
        int rf, cnt, d;
        bit lk;
        lk = 1'b0; cnt = 0;
        if (hist.size() == 0) begin
            m_locked = 1'b0;
            return;
        end
        rf = hist[0];
        for (int i = 1; i < hist.size(); i++) begin
            d = (hist[i] > rf) ? hist[i] - rf : rf - hist[i];
            if (d <= TOL) begin
                if (!lk) begin
                    cnt++;
                    if (cnt == LOCK) begin
                        lk = 1'b1;
                        m_wl = (2 * rf > 65535) ? 65535 : 2 * rf;
                    end
                end
            end else begin
                rf = hist[i]; cnt = 0; lk = 1'b0;
            end
        end
        m_locked = lk;
    endfunction

    function automatic void modelStep(input bit v, input logic [31:0] s);
        bit          p;
        logic [31:0] mag, old;
        e_set = 1'b0; e_ss = '0; e_sc = 0;
        if (!v) return;
        p   = !s[31];
        mag = (s == 32'h8000_0000) ? 32'h7FFF_FFFF : (s[31] ? 32'd0 - s : s);
        if (p != m_pol) begin
            old = m_peak;
            if (m_seen) begin
                hist.push_back(m_run);
                m_amp = old;
                walkHistory();
            end
            m_seen = 1'b1; m_pol = p; m_run = 1; m_peak = mag;
`ifdef SQUARE_ANALYZER_RESYNC_EN
            if (m_locked) begin
                e_set = 1'b1;
                e_ss  = p ? old : 32'd0 - old;
                e_sc  = 2;
            end
`endif
        end else begin
            if (mag > m_peak) m_peak = mag;
            if (m_run == MAXH) begin
                hist.delete(); m_seen = 1'b0; m_locked = 1'b0;
            end else begin
                m_run++;
            end
        end
    endfunction

    task automatic checkAll();
        checkOutput("locked",      32'(locked),      32'(m_locked));
        checkOutput("wave_length", 32'(wave_length), 32'(m_wl));
        checkOutput("amplitude",   amplitude,        m_amp);
        checkOutput("phase",       32'(phase),       32'(m_run));
        checkOutput("polarity",    32'(polarity),    32'(m_pol));
        checkOutput("set",         32'(set),         32'(e_set));
        checkOutput("set_sample",  set_sample,       e_ss);
        checkOutput("set_counter", 32'(set_counter), 32'(e_sc));
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] s);
        sample_valid = v;
        sample       = s;
        @(posedge clk);
        modelStep(v, s);
        #1;
        checkAll();
    endtask

    task automatic sendHalf(input int len, input bit fixed, input logic [31:0] mag);
        logic [31:0] s;
        for (int i = 0; i < len; i++) begin
            if (gap_en && $urandom_range(0, 4) == 0)
                applyStimulus(1'b0, $urandom);
            if (fixed)
                s = next_pos ? mag : 32'd0 - mag;
            else if (next_pos)
                s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32'h7FFF_FFFF) : $urandom_range(0, 1000);
            else if ($urandom_range(0, 9) == 0)
                s = 32'h8000_0000;
            else
                s = 32'd0 - (($urandom_range(0, 3) == 0) ? $urandom_range(1, 32'h7FFF_FFFF) : $urandom_range(1, 1000));
            applyStimulus(1'b1, s);
        end
        next_pos = !next_pos;
    endtask

    initial begin
        int base, len;
        reset = 1'b1; sample_valid = 1'b0; sample = '0;
        gap_en = 1'b0; next_pos = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        checkOutput("rst_polarity", 32'(polarity), 32'd1);
        reset = 1'b0;

        // Clean 10/10 wave locks on the fifth edge.
        repeat (6) sendHalf(10, 1'b1, 32'd1048576);
        checkOutput("s2_locked", 32'(locked),      32'd1);
        checkOutput("s2_wl",     32'(wave_length), 32'd20);
        checkOutput("s2_amp",    amplitude,        32'd1048576);

        // A 12-sample half breaks lock; three more matching halves relock at 24.
        repeat (2) sendHalf(12, 1'b1, 32'd1048576);
        checkOutput("s3_unlocked", 32'(locked), 32'd0);
        repeat (3) sendHalf(12, 1'b1, 32'd1048576);
        checkOutput("s3_relocked", 32'(locked),      32'd1);
        checkOutput("s3_wl",       32'(wave_length), 32'd24);

        // Asynchronous reset in the middle of a locked half.
        sendHalf(5, 1'b1, 32'd777);
        sample_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_mid_locked", 32'(locked), 32'd0);
        checkOutput("rst_mid_set",    32'(set),    32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        next_pos = 1'b1;

        // Jitter within tolerance keeps the lock.
        repeat (6) sendHalf(10, 1'b1, 32'd1048576);
        sendHalf(10, 1'b1, 32'd500);
        sendHalf(11, 1'b1, 32'd600);
        sendHalf(9,  1'b1, 32'd700);
        sendHalf(10, 1'b1, 32'd800);
        sendHalf(10, 1'b1, 32'd900);
        checkOutput("s4_locked", 32'(locked),      32'd1);
        checkOutput("s4_wl",     32'(wave_length), 32'd20);

        // Flat zero input times out and parks the counter.
        repeat (110) applyStimulus(1'b1, 32'd0);
        checkOutput("s5_locked", 32'(locked), 32'd0);
        checkOutput("s5_phase",  32'(phase),  32'd100);
        checkOutput("s5_wl",     32'(wave_length), 32'd20);
        next_pos = 1'b0;

        gap_en = 1'b1;
        base = 10;
        for (int k = 0; k < 300; k++) begin
            if (k % 20 == 0) base = $urandom_range(2, 30);
            len = base + int'($urandom_range(0, 2)) - 1;
            if ($urandom_range(0, 14) == 0) len = $urandom_range(1, 60);
            if ($urandom_range(0, 39) == 0) len = $urandom_range(100, 115);
            sendHalf(len, 1'b0, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
